// File: rtl/doorlock_supervisor_pkg.sv
// doorlock_supervisor_pkg: shared state encoding and default interval constants
package doorlock_supervisor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_ALARM   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;
  localparam longint DEF_OPEN_CYCLES    = 50_000_000;
  localparam longint DEF_ALARM_CYCLES   = 25_000_000;
  localparam longint DEF_LOCKOUT_CYCLES = 500_000_000;
  localparam int     DEF_MAX_FAIL       = 3;
endpackage

// File: rtl/doorlock_supervisor_down_timer.sv
// down_timer: loadable 32-bit down-counter that holds at zero
module down_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);
  logic [31:0] timer;
  always_ff @(posedge clk)
    timer <= !n_rst ? '0 : load ? load_val : zero ? timer : timer - 32'd1;
  assign zero = timer == '0;
endmodule

// File: rtl/doorlock_supervisor.sv
// doorlock_supervisor: stretches core open/alarm pulses, counts failures, enforces lockout and key gating
module doorlock_supervisor
  import doorlock_supervisor_pkg::*;
#(
  parameter longint OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter longint ALARM_CYCLES   = DEF_ALARM_CYCLES,
  parameter longint LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int     MAX_FAIL       = DEF_MAX_FAIL
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_star,
  input  logic       key_sharp,
  input  logic [9:0] key_number,
  input  logic       core_open,
  input  logic       core_alarm,
  output logic       core_star,
  output logic       core_sharp,
  output logic [9:0] core_number,
  output logic       open,
  output logic       alarm,
  output logic       locked,
  output logic [3:0] fail_cnt
);
  state_t state, state_nxt;
  logic [3:0] fail_nxt, fail_inc;
  logic load, zero, idle, trip;
  logic [31:0] load_val;
  assign idle     = state == ST_IDLE;
  assign fail_inc = fail_cnt == 4'(MAX_FAIL) ? fail_cnt : fail_cnt + 4'd1;
  assign trip     = fail_inc == 4'(MAX_FAIL);
  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_cnt;
    load      = 1'b0;
    load_val  = '0;
    if (idle) begin
      if (core_open) begin
        state_nxt = ST_OPEN;
        load      = 1'b1;
        load_val  = 32'(OPEN_CYCLES - 1);
        fail_nxt  = '0;
      end else if (core_alarm) begin
        state_nxt = trip ? ST_LOCKOUT : ST_ALARM;
        load      = 1'b1;
        load_val  = trip ? 32'(LOCKOUT_CYCLES - 1) : 32'(ALARM_CYCLES - 1);
        fail_nxt  = fail_inc;
      end
    end else if (zero) begin
      state_nxt = ST_IDLE;
      fail_nxt  = state == ST_LOCKOUT ? '0 : fail_cnt;
    end
  end
  always_ff @(posedge clk) begin
    state    <= !n_rst ? ST_IDLE : state_nxt;
    fail_cnt <= !n_rst ? '0 : fail_nxt;
  end
  down_timer u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (load),
    .load_val(load_val),
    .zero    (zero)
  );
  assign open        = state == ST_OPEN;
  assign alarm       = state == ST_ALARM || state == ST_LOCKOUT;
  assign locked      = state == ST_LOCKOUT;
  assign core_star   = key_star & idle;
  assign core_sharp  = key_sharp & idle;
  assign core_number = idle ? key_number : '0;
endmodule
